mem_dma: RTL

- Bus initiator that drives the memory word port (marval / mdrval / mrw / memout) to perform block copy or block fill without controller involvement.
- Sits beside the datapath in top and shares the memory port with it. Top muxes the port to mem_dma while busy=1.
- Memory semantics it is built against:
  - Combinational read: memout = mem[marval].
  - Synchronous write on posedge clk when mrw=1.

---
 rtl/mem_dma_if.sv | 30 +++
 rtl/mem_dma.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/mem_dma_if.sv
`default_nettype none
// ============================================================================
//  Module   : mem_dma_if
//  Purpose  : Memory word port between a bus initiator and a word memory.
//  Revision : 1.0
// ============================================================================
interface mem_dma_if #(
   parameter int DW = 16,
   parameter int AW = 16
);
   logic [AW-1:0] marval;
   logic [DW-1:0] mdrval;
   logic          mrw;
   logic [DW-1:0] memout;

   modport master (
      output marval,
      output mdrval,
      output mrw,
      input  memout
   );

   modport slave (
      input  marval,
      input  mdrval,
      input  mrw,
      output memout
   );
endinterface : mem_dma_if
`default_nettype wire

// File: rtl/mem_dma.sv
`default_nettype none
// ============================================================================
//  Module   : mem_dma
//  Purpose  : Block copy / block fill engine driving the shared memory port.
//  Revision : 1.0
// ============================================================================
module mem_dma #(
   parameter int DW    = 16,
   parameter int AW    = 16,
   parameter int DEPTH = 4096
) (
   input  wire logic          clk,
   input  wire logic          reset,
   input  wire logic          start,
   input  wire logic          mode,
   input  wire logic [AW-1:0] src,
   input  wire logic [AW-1:0] dst,
   input  wire logic [15:0]   len,
   input  wire logic [DW-1:0] fill_val,
   mem_dma_if.master          mem,
   output logic               busy,
   output logic               done,
   output logic [15:0]        xfer_cnt
);

   localparam logic [31:0]   c_DEPTH = 32'(DEPTH);
   localparam logic [AW-1:0] c_LAST  = AW'(DEPTH - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_READ  = 2'd1,
      S_WRITE = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t        r_state;
   state_t        w_next;

   logic [AW-1:0] r_src_ptr;
   logic [AW-1:0] r_dst_ptr;
   logic [15:0]   r_remaining;
   logic [DW-1:0] r_data;
   logic          r_mode;
   logic [DW-1:0] r_fill;
   logic [15:0]   r_xfer_cnt;

   logic [AW-1:0] w_marval;
   logic [DW-1:0] w_mdrval;
   logic          w_mrw;

   // Out-of-range start addresses fold back into the memory.
   function automatic logic [AW-1:0] f_reduce(input logic [AW-1:0] a);
      return AW'(32'(a) % c_DEPTH);
   endfunction

   function automatic logic [AW-1:0] f_inc(input logic [AW-1:0] p);
      return (p == c_LAST) ? '0 : p + 1'b1;
   endfunction

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next   = r_state;
      w_marval = '0;
      w_mdrval = '0;
      w_mrw    = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (start) begin
               if (len == 16'd0) begin
                  w_next = S_DONE;
               end else if (mode) begin
                  w_next = S_WRITE;
               end else begin
                  w_next = S_READ;
               end
            end
         end
         S_READ: begin
            w_marval = r_src_ptr;
            w_next   = S_WRITE;
         end
         S_WRITE: begin
            w_marval = r_dst_ptr;
            w_mrw    = 1'b1;
            w_mdrval = r_mode ? r_fill : r_data;
            if (r_remaining == 16'd1) begin
               w_next = S_DONE;
            end else if (r_mode) begin
               w_next = S_WRITE;
            end else begin
               w_next = S_READ;
            end
         end
         S_DONE: begin
            w_next = S_IDLE;
         end
         default: begin
            w_next = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_src_ptr   <= '0;
         r_dst_ptr   <= '0;
         r_remaining <= '0;
         r_data      <= '0;
         r_mode      <= 1'b0;
         r_fill      <= '0;
         r_xfer_cnt  <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_src_ptr   <= f_reduce(src);
                  r_dst_ptr   <= f_reduce(dst);
                  r_remaining <= len;
                  r_mode      <= mode;
                  r_fill      <= fill_val;
                  r_xfer_cnt  <= '0;
               end
            end
            S_READ: begin
               r_data    <= mem.memout;
               r_src_ptr <= f_inc(r_src_ptr);
            end
            S_WRITE: begin
               r_dst_ptr   <= f_inc(r_dst_ptr);
               r_remaining <= r_remaining - 16'd1;
               r_xfer_cnt  <= r_xfer_cnt + 16'd1;
            end
            default: begin
            end
         endcase
      end
   end

   assign mem.marval = w_marval;
   assign mem.mdrval = w_mdrval;
   assign mem.mrw    = w_mrw;
   assign busy       = (r_state != S_IDLE);
   assign done       = (r_state == S_DONE);
   assign xfer_cnt   = r_xfer_cnt;

endmodule : mem_dma
`default_nettype wire
